bram_portb_arbiter: RTL and testbench

Shares the single BRAM data port (port B) between the CPU MEM stage and an auxiliary master (boot loader / debug DMA). After reset the block is in BOOT mode, where the auxiliary master owns the port exclusively while the pipeline is held. After boot_done it switches to RUN mode: CPU priority, with a starvation guard for the auxiliary master. Grants and the port mux are combinational; read-return routing is registered to match the 1-cycle BRAM read latency.

---
 rtl/bram_portb_arbiter_pkg.sv | 38 +++
 rtl/bram_portb_arbiter_wait_counter.sv | 37 +++
 rtl/bram_portb_arbiter.sv | 141 ++++++++++++++
 tb/tb_bram_portb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_portb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bram_portb_arbiter_pkg
// Shared types and constants for the BRAM port-B arbiter:
//   state_t  - arbiter mode (BOOT: aux owns the port, RUN: CPU priority)
//   owner_t  - which requester the read data returning next cycle belongs to
//   read_owner() - classifies this cycle's granted access for read return
// -----------------------------------------------------------------------------
package bram_portb_arbiter_pkg;

  localparam int WAIT_W = 8;  // starvation counter width
  localparam int WE_W   = 4;  // byte write strobes per word

  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  // Only reads (all strobes clear) expect data back; writes return nothing.
  function automatic owner_t read_owner(
    input logic            cpu_gnt,
    input logic [WE_W-1:0] cpu_we,
    input logic            aux_gnt,
    input logic [WE_W-1:0] aux_we
  );
    if (cpu_gnt && (cpu_we == '0)) return OWN_CPU;
    if (aux_gnt && (aux_we == '0)) return OWN_AUX;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/bram_portb_arbiter_wait_counter.sv
// -----------------------------------------------------------------------------
// bram_portb_arbiter_wait_counter
// Saturating starvation counter for the auxiliary master.
//   clk, rst  - clock, asynchronous active-low reset
//   inc       - aux was denied this cycle
//   clr       - aux was granted, is not requesting, or arbiter is in BOOT
//   reached   - count has reached LIMIT; aux must be forced a grant
// -----------------------------------------------------------------------------
module bram_portb_arbiter_wait_counter
  import bram_portb_arbiter_pkg::*;
#(
  parameter logic [WAIT_W-1:0] LIMIT = WAIT_W'(8)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic reached
);

  logic [WAIT_W-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIMIT)) begin
      cnt <= cnt + WAIT_ONE;
    end
  end

  assign reached = (cnt >= LIMIT);

endmodule

// File: rtl/bram_portb_arbiter.sv
// -----------------------------------------------------------------------------
// bram_portb_arbiter
// Shares BRAM port B between the CPU MEM stage and an auxiliary master
// (boot loader / debug DMA).
//   BOOT mode: aux owns the port, CPU is stalled unconditionally.
//   RUN mode : CPU has priority; aux is forced a grant after MAX_WAIT
//              consecutive denied cycles.
// Grants and the port mux are combinational; read-return routing is a
// registered owner tag matching the 1-cycle BRAM read latency.
// Ports:
//   clk, rst                         clock, async active-low reset
//   boot_done / run_mode             leave BOOT / currently in RUN
//   cpu_req/we/addr/wdata            CPU request   -> cpu_stall, cpu_rdata/rvalid
//   aux_req/we/addr/wdata            aux request   -> aux_gnt, aux_rdata/rvalid
//   bram_en/we/addr/wdata, bram_rdata  BRAM port B
// -----------------------------------------------------------------------------
module bram_portb_arbiter
  import bram_portb_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter bit BOOT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              boot_done,
  output logic              run_mode,
  input  logic              cpu_req,
  input  logic [WE_W-1:0]   cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              aux_req,
  input  logic [WE_W-1:0]   aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic              bram_en,
  output logic [WE_W-1:0]   bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  state_t state;
  owner_t rd_owner;
  logic   in_run;
  logic   cpu_gnt;
  logic   force_aux;
  logic   wait_reached;

  assign in_run   = (state == ST_RUN);
  assign run_mode = in_run;

  // ---------------------------------------------------------------------------
  // Mode: BOOT -> RUN on boot_done; only reset returns to BOOT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT_EN ? ST_BOOT : ST_RUN;
    end else if ((state == ST_BOOT) && boot_done) begin
      state <= ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation guard. The counter only sees registered history, so the
  // reached -> grant -> clr path has no combinational loop.
  // ---------------------------------------------------------------------------
  bram_portb_arbiter_wait_counter #(
    .LIMIT (WAIT_W'(MAX_WAIT))
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (in_run & aux_req & ~aux_gnt),
    .clr     (~in_run | ~aux_req | aux_gnt),
    .reached (wait_reached)
  );

  assign force_aux = aux_req & wait_reached;

  // ---------------------------------------------------------------------------
  // Grants (same cycle as request)
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cpu_gnt   = 1'b0;
    aux_gnt   = aux_req;
    cpu_stall = 1'b1;
    if (in_run) begin
      cpu_gnt   = cpu_req & ~force_aux;
      aux_gnt   = aux_req & (force_aux | ~cpu_req);
      cpu_stall = cpu_req & ~cpu_gnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Port mux: grants are mutually exclusive; idle drives zeros.
  // ---------------------------------------------------------------------------
  assign bram_en = cpu_gnt | aux_gnt;

  always_comb begin
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    if (cpu_gnt) begin
      bram_we    = cpu_we;
      bram_addr  = cpu_addr;
      bram_wdata = cpu_wdata;
    end else if (aux_gnt) begin
      bram_we    = aux_we;
      bram_addr  = aux_addr;
      bram_wdata = aux_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: tag the owner of the data BRAM will present next cycle.
  // Updated every cycle, so alternating back-to-back reads route correctly,
  // and reset drops any read in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= read_owner(cpu_gnt, cpu_we, aux_gnt, aux_we);
    end
  end

  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign aux_rvalid = (rd_owner == OWN_AUX);
  assign cpu_rdata  = bram_rdata;
  assign aux_rdata  = bram_rdata;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_portb_arbiter
// Directed bench for bram_portb_arbiter. Two instances share the clock:
// u_dut (BOOT_EN=1) and u_dut_nb (BOOT_EN=0), each with its own BRAM model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// so combinational grants and registered read-return flags are both stable.
// -----------------------------------------------------------------------------
module tb_bram_portb_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: BOOT_EN = 1 ----------------
  logic              rst, boot_done, run_mode;
  logic              cpu_req, cpu_stall, cpu_rvalid;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              aux_req, aux_gnt, aux_rvalid;
  logic [3:0]        aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata, aux_rdata;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;

  // ---------------- instance B: BOOT_EN = 0 ----------------
  logic              b_rst, b_boot_done, b_run_mode;
  logic              b_cpu_req, b_cpu_stall, b_cpu_rvalid;
  logic [3:0]        b_cpu_we;
  logic [ADDR_W-1:0] b_cpu_addr;
  logic [DATA_W-1:0] b_cpu_wdata, b_cpu_rdata;
  logic              b_aux_req, b_aux_gnt, b_aux_rvalid;
  logic [3:0]        b_aux_we;
  logic [ADDR_W-1:0] b_aux_addr;
  logic [DATA_W-1:0] b_aux_wdata, b_aux_rdata;
  logic              b_bram_en;
  logic [3:0]        b_bram_we;
  logic [ADDR_W-1:0] b_bram_addr;
  logic [DATA_W-1:0] b_bram_wdata, b_bram_rdata;

  bram_portb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(8), .BOOT_EN(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .boot_done(boot_done), .run_mode(run_mode),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  bram_portb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(8), .BOOT_EN(1'b0)
  ) u_dut_nb (
    .clk(clk), .rst(b_rst), .boot_done(b_boot_done), .run_mode(b_run_mode),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_stall(b_cpu_stall), .cpu_rdata(b_cpu_rdata), .cpu_rvalid(b_cpu_rvalid),
    .aux_req(b_aux_req), .aux_we(b_aux_we), .aux_addr(b_aux_addr), .aux_wdata(b_aux_wdata),
    .aux_gnt(b_aux_gnt), .aux_rdata(b_aux_rdata), .aux_rvalid(b_aux_rvalid),
    .bram_en(b_bram_en), .bram_we(b_bram_we), .bram_addr(b_bram_addr),
    .bram_wdata(b_bram_wdata), .bram_rdata(b_bram_rdata)
  );

  // BRAM models: read-first, 1-cycle latency, byte strobes.
  // Word i is preloaded with 0xA5A5_0000 | i.
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = 32'hA5A5_0000 | 32'(i);
      mem_b[i] = 32'hA5A5_0000 | 32'(i);
    end
  end

  always @(posedge clk) begin
    if (bram_en) begin
      bram_rdata <= mem_a[bram_addr];
      for (int i = 0; i < 4; i++)
        if (bram_we[i]) mem_a[bram_addr][8*i +: 8] <= bram_wdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (b_bram_en) begin
      b_bram_rdata <= mem_b[b_bram_addr];
      for (int i = 0; i < 4; i++)
        if (b_bram_we[i]) mem_b[b_bram_addr][8*i +: 8] <= b_bram_wdata[8*i +: 8];
    end
  end

  task automatic idle_a();
    boot_done = 1'b0;
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 1'b0; aux_we = 4'h0; aux_addr = '0; aux_wdata = '0;
  endtask

  task automatic idle_b();
    b_boot_done = 1'b0;
    b_cpu_req = 1'b0; b_cpu_we = 4'h0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_aux_req = 1'b0; b_aux_we = 4'h0; b_aux_addr = '0; b_aux_wdata = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; b_rst = 1'b0;
    idle_a(); idle_b();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (run_mode !== 1'b0) begin errors++; $display("FAIL rst_run_mode got %b want 0", run_mode); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_cpu_stall got %b want 1", cpu_stall); end
    checks++; if ({cpu_rvalid, aux_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", {cpu_rvalid, aux_rvalid}); end
    checks++; if (bram_en !== 1'b0) begin errors++; $display("FAIL rst_bram_en got %b want 0", bram_en); end
    checks++; if (b_run_mode !== 1'b1) begin errors++; $display("FAIL rst_nb_run_mode got %b want 1", b_run_mode); end
    checks++; if (b_cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_nb_cpu_stall got %b want 0", b_cpu_stall); end
    @(negedge clk);
    rst = 1'b1; b_rst = 1'b1;
  endtask

  // BOOT: aux writes DEADBEEF to 0x010 then reads it back; CPU stays stalled.
  task automatic test_boot_aux();
    @(negedge clk);
    aux_req = 1'b1; aux_we = 4'hF; aux_addr = 11'h010; aux_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (aux_gnt !== 1'b1) begin errors++; $display("FAIL boot_wr_gnt got %b want 1", aux_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL boot_wr_stall got %b want 1", cpu_stall); end
    checks++; if ({bram_en, bram_we} !== 5'b1_1111) begin errors++; $display("FAIL boot_wr_en_we got %b want 11111", {bram_en, bram_we}); end
    checks++; if (bram_addr !== 11'h010) begin errors++; $display("FAIL boot_wr_addr got %h want 010", bram_addr); end
    checks++; if (bram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL boot_wr_wdata got %h want deadbeef", bram_wdata); end

    @(negedge clk);
    aux_we = 4'h0; aux_wdata = '0; cpu_req = 1'b1; cpu_addr = 11'h004;
    #1;
    checks++; if (aux_gnt !== 1'b1) begin errors++; $display("FAIL boot_rd_gnt got %b want 1", aux_gnt); end
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL boot_rd_stall_cpureq got %b want 1", cpu_stall); end
    checks++; if (bram_addr !== 11'h010) begin errors++; $display("FAIL boot_rd_addr got %h want 010", bram_addr); end
    checks++; if (aux_rvalid !== 1'b0) begin errors++; $display("FAIL boot_wr_no_rvalid got %b want 0", aux_rvalid); end

    @(negedge clk);
    idle_a();
    #1;
    checks++; if (aux_rvalid !== 1'b1) begin errors++; $display("FAIL boot_rd_rvalid got %b want 1", aux_rvalid); end
    checks++; if (aux_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL boot_rd_rdata got %h want deadbeef", aux_rdata); end
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL boot_rd_cpu_rvalid got %b want 0", cpu_rvalid); end
    checks++; if ({bram_en, cpu_stall} !== 2'b01) begin errors++; $display("FAIL boot_idle_en_stall got %b want 01", {bram_en, cpu_stall}); end
  endtask

  // boot_done coincides with an aux read; the read still returns in RUN.
  task automatic test_boot_exit();
    @(negedge clk);
    boot_done = 1'b1; aux_req = 1'b1; aux_we = 4'h0; aux_addr = 11'h010;
    #1;
    checks++; if ({run_mode, aux_gnt} !== 2'b01) begin errors++; $display("FAIL exit_pulse_mode_gnt got %b want 01", {run_mode, aux_gnt}); end

    @(negedge clk);
    idle_a();
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 11'h010;
    #1;
    checks++; if (run_mode !== 1'b1) begin errors++; $display("FAIL exit_run_mode got %b want 1", run_mode); end
    checks++; if (aux_rvalid !== 1'b1) begin errors++; $display("FAIL exit_aux_rvalid got %b want 1", aux_rvalid); end
    checks++; if (aux_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL exit_aux_rdata got %h want deadbeef", aux_rdata); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL exit_cpu_stall got %b want 0", cpu_stall); end
    checks++; if ({bram_en, bram_addr} !== {1'b1, 11'h010}) begin errors++; $display("FAIL exit_cpu_port got %h want 810", {bram_en, bram_addr}); end

    @(negedge clk);
    idle_a();
    #1;
    checks++; if ({cpu_rvalid, aux_rvalid} !== 2'b10) begin errors++; $display("FAIL exit_cpu_rvalid got %b want 10", {cpu_rvalid, aux_rvalid}); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL exit_cpu_rdata got %h want deadbeef", cpu_rdata); end
  endtask

  // Both requesters held for n cycles (CPU reads 0x004, aux reads 0x008).
  // With MAX_WAIT=8 aux is forced every 9th cycle, then a drain cycle.
  task automatic test_starvation(input int n);
    logic prev_cpu = 1'b0;
    logic prev_aux = 1'b0;
    logic exp_aux;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      boot_done = 1'b0;
      cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 11'h004;
      aux_req = 1'b1; aux_we = 4'h0; aux_addr = 11'h008;
      #1;
      exp_aux = ((c % 9) == 0);
      checks++; if (aux_gnt !== exp_aux) begin errors++; $display("FAIL starve_aux_gnt c=%0d got %b want %b", c, aux_gnt, exp_aux); end
      checks++; if (cpu_stall !== exp_aux) begin errors++; $display("FAIL starve_cpu_stall c=%0d got %b want %b", c, cpu_stall, exp_aux); end
      checks++; if (bram_addr !== (exp_aux ? 11'h008 : 11'h004)) begin errors++; $display("FAIL starve_addr c=%0d got %h", c, bram_addr); end
      checks++; if ({cpu_rvalid, aux_rvalid} !== {prev_cpu, prev_aux}) begin errors++; $display("FAIL starve_rvalid c=%0d got %b want %b", c, {cpu_rvalid, aux_rvalid}, {prev_cpu, prev_aux}); end
      if (prev_cpu) begin
        checks++; if (cpu_rdata !== 32'hA5A5_0004) begin errors++; $display("FAIL starve_cpu_rdata c=%0d got %h want a5a50004", c, cpu_rdata); end
      end
      prev_cpu = ~exp_aux;
      prev_aux = exp_aux;
    end
    @(negedge clk);
    idle_a();
    #1;
    checks++; if ({cpu_rvalid, aux_rvalid} !== {prev_cpu, prev_aux}) begin errors++; $display("FAIL starve_drain_rvalid got %b want %b", {cpu_rvalid, aux_rvalid}, {prev_cpu, prev_aux}); end
    checks++; if ({bram_en, bram_we, bram_addr, bram_wdata} !== '0) begin errors++; $display("FAIL starve_idle_port got %b %h %h %h want zeros", bram_en, bram_we, bram_addr, bram_wdata); end
  endtask

  // Alternating CPU then aux reads: rvalids on successive cycles, never both.
  task automatic test_back_to_back();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 11'h004;
    #1;
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL b2b_cpu_stall got %b want 0", cpu_stall); end

    @(negedge clk);
    idle_a();
    aux_req = 1'b1; aux_we = 4'h0; aux_addr = 11'h008;
    #1;
    checks++; if (aux_gnt !== 1'b1) begin errors++; $display("FAIL b2b_aux_gnt got %b want 1", aux_gnt); end
    checks++; if ({cpu_rvalid, aux_rvalid} !== 2'b10) begin errors++; $display("FAIL b2b_rv1 got %b want 10", {cpu_rvalid, aux_rvalid}); end
    checks++; if (cpu_rdata !== 32'hA5A5_0004) begin errors++; $display("FAIL b2b_cpu_rdata got %h want a5a50004", cpu_rdata); end

    @(negedge clk);
    idle_a();
    #1;
    checks++; if ({cpu_rvalid, aux_rvalid} !== 2'b01) begin errors++; $display("FAIL b2b_rv2 got %b want 01", {cpu_rvalid, aux_rvalid}); end
    checks++; if (aux_rdata !== 32'hA5A5_0008) begin errors++; $display("FAIL b2b_aux_rdata got %h want a5a50008", aux_rdata); end
  endtask

  // Build up aux wait history, then reset with a CPU read in flight.
  task automatic test_reset_in_flight();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 11'h004;
      aux_req = 1'b1; aux_we = 4'h0; aux_addr = 11'h008;
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rif_pre_stall c=%0d got %b want 0", c, cpu_stall); end
    end

    @(negedge clk);
    rst = 1'b0;
    idle_a();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rif_cpu_rvalid got %b want 0", cpu_rvalid); end
    checks++; if (run_mode !== 1'b0) begin errors++; $display("FAIL rif_run_mode got %b want 0", run_mode); end

    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({cpu_rvalid, cpu_stall} !== 2'b01) begin errors++; $display("FAIL rif_release got %b want 01", {cpu_rvalid, cpu_stall}); end

    @(negedge clk);
    boot_done = 1'b1;
    #1;
    checks++; if (run_mode !== 1'b0) begin errors++; $display("FAIL rif_boot_pulse got %b want 0", run_mode); end
    // A fresh 9-cycle contention window proves the wait count restarted at 0.
    test_starvation(9);
  endtask

  // BOOT_EN=0 instance: RUN from reset, boot_done ignored, partial write.
  task automatic test_boot_disabled();
    @(negedge clk);
    b_boot_done = 1'b1;
    #1;
    checks++; if (b_run_mode !== 1'b1) begin errors++; $display("FAIL nb_run_mode got %b want 1", b_run_mode); end

    @(negedge clk);
    b_boot_done = 1'b0;
    b_cpu_req = 1'b1; b_cpu_we = 4'b0011; b_cpu_addr = 11'h020; b_cpu_wdata = 32'h1234_5678;
    #1;
    checks++; if (b_run_mode !== 1'b1) begin errors++; $display("FAIL nb_after_pulse got %b want 1", b_run_mode); end
    checks++; if ({b_cpu_stall, b_bram_en, b_bram_we} !== 6'b0_1_0011) begin errors++; $display("FAIL nb_wr_port got %b want 010011", {b_cpu_stall, b_bram_en, b_bram_we}); end
    checks++; if ({b_bram_addr, b_bram_wdata} !== {11'h020, 32'h1234_5678}) begin errors++; $display("FAIL nb_wr_addr_data got %h %h", b_bram_addr, b_bram_wdata); end

    @(negedge clk);
    b_cpu_we = 4'h0; b_cpu_wdata = '0;
    #1;
    checks++; if ({b_cpu_rvalid, b_aux_rvalid, b_aux_gnt} !== 3'b000) begin errors++; $display("FAIL nb_wr_no_rvalid got %b want 000", {b_cpu_rvalid, b_aux_rvalid, b_aux_gnt}); end

    @(negedge clk);
    idle_b();
    #1;
    checks++; if (b_cpu_rvalid !== 1'b1) begin errors++; $display("FAIL nb_rd_rvalid got %b want 1", b_cpu_rvalid); end
    checks++; if (b_cpu_rdata !== 32'hA5A5_5678) begin errors++; $display("FAIL nb_rd_rdata got %h want a5a55678", b_cpu_rdata); end
    checks++; if (b_aux_rdata !== 32'hA5A5_5678) begin errors++; $display("FAIL nb_aux_rdata_pass got %h want a5a55678", b_aux_rdata); end
  endtask

  initial begin
    test_reset();
    test_boot_aux();
    test_boot_exit();
    test_starvation(18);
    test_back_to_back();
    test_reset_in_flight();
    test_boot_disabled();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
